// File: rtl/dyn_add_host_pkg.sv
// dyn_add_host_pkg: shared state encoding and default sizing for the dynamic-adder host
package dyn_add_host_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_MAX_WAIT = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
endpackage

// File: rtl/dyn_add_host_if.sv
// dyn_add_host_if: upstream, adder-side and downstream signals of the dynamic-adder host
interface dyn_add_host_if import dyn_add_host_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic in_valid, in_ready, in_cin;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] add_A, add_B, add_sum;
  logic add_Cin, add_F, add_request, add_done, add_Cout;
  logic out_valid, out_ready, out_cout, out_timeout;
  logic [WIDTH-1:0] out_sum;
  modport slave (
    input in_valid, in_a, in_b, in_cin, add_done, add_sum, add_Cout, out_ready,
    output in_ready, add_A, add_B, add_Cin, add_F, add_request, out_valid, out_sum, out_cout, out_timeout
  );
  modport master (
    output in_valid, in_a, in_b, in_cin, add_done, add_sum, add_Cout, out_ready,
    input in_ready, add_A, add_B, add_Cin, add_F, add_request, out_valid, out_sum, out_cout, out_timeout
  );
endinterface

// File: rtl/dyn_add_host_wait_timer.sv
// dyn_add_host_wait_timer: WAIT-state cycle counter with clear, enable and terminal-count flag
module dyn_add_host_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  end
  assign tc = en && (cnt == 8'(MAX_WAIT - 1));
endmodule

// File: rtl/dyn_add_host.sv
// dyn_add_host: launches one operand pair into a dynamic adder and captures its result or times out
module dyn_add_host import dyn_add_host_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input logic clk,
  input logic rst,
  dyn_add_host_if.slave bus
);
  state_t state, nxt;
  logic rdy_q, tc, acc, cap;
  assign acc = bus.in_ready && bus.in_valid;
  assign cap = (state == WAIT) && (bus.add_done || tc);
  dyn_add_host_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .rst(rst), .clr(state != WAIT), .en(state == WAIT), .tc(tc)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = (state == IDLE)   ? (acc ? LAUNCH : IDLE) :
          (state == LAUNCH) ? WAIT :
          (state == WAIT)   ? (cap ? HOLD : WAIT) :
                              (bus.out_ready ? IDLE : HOLD);
  end
  // rdy_q keeps in_ready low until the first edge after reset releases
  always_comb begin
    bus.in_ready = (state == IDLE) && rdy_q;
    bus.add_F = state == LAUNCH;
    bus.add_request = state == WAIT;
    bus.out_valid = state == HOLD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      bus.add_A <= '0;
      bus.add_B <= '0;
      bus.add_Cin <= 1'b0;
      bus.out_sum <= '0;
      bus.out_cout <= 1'b0;
      bus.out_timeout <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (acc) begin
        bus.add_A <= bus.in_a;
        bus.add_B <= bus.in_b;
        bus.add_Cin <= bus.in_cin;
      end
      if (cap) begin
        bus.out_sum <= bus.add_sum;
        bus.out_cout <= bus.add_Cout;
        bus.out_timeout <= !bus.add_done;
      end
    end
  end
endmodule
